// File: rtl/bm_pkg.sv
// Shared constants, types and the branch distance function for the branch-metric table.
// BM_SOFT_DECISION_EN selects the soft L1 metric; when it is undefined, the Hamming metric is used.
package bm_pkg;

  localparam int N_OUT      = 6;
  localparam int STATE_BITS = 8;
  localparam int RADIX_BITS = 2;
  localparam int Q          = 3;

  localparam int NUM_STATES = 2 ** STATE_BITS;
  localparam int RADIX      = 2 ** RADIX_BITS;
  localparam int NUM_BRANCH = NUM_STATES * RADIX;
  localparam int IDX_W      = STATE_BITS + RADIX_BITS;
  localparam int MAXQ       = 2 ** Q - 1;

`ifdef BM_SOFT_DECISION_EN
  localparam int MW = $clog2(N_OUT * MAXQ + 1);
`else
  localparam int MW = $clog2(N_OUT + 1);
`endif

  typedef logic [MW-1:0]      metric_t;
  typedef logic [N_OUT-1:0]   code_t;
  typedef logic [N_OUT*Q-1:0] rx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fsm_t;

  function automatic metric_t bm_dist(input code_t code, input rx_t rx);
    metric_t acc;
`ifdef BM_SOFT_DECISION_EN
    logic [Q-1:0] s;
    logic [Q-1:0] e;
    logic [Q-1:0] d;
`endif
    acc = '0;
    for (int i = 0; i < N_OUT; i++) begin
`ifdef BM_SOFT_DECISION_EN
      s   = rx[i*Q +: Q];
      e   = code[i] ? Q'(MAXQ) : '0;
      d   = (s > e) ? (s - e) : (e - s);
      acc = acc + metric_t'(d);
`else
      acc = acc + metric_t'(rx[i*Q + Q - 1] ^ code[i]);
`endif
    end
    return acc;
  endfunction

endpackage

// File: rtl/bm_branch_calc.sv
// Combinational metric for a single trellis branch.
// BM_SOFT_DECISION_EN selects soft L1 distance instead of Hamming distance.
module bm_branch_calc
  import bm_pkg::*;
(
  input  logic [N_OUT-1:0]   code,
  input  logic [N_OUT*Q-1:0] rx,
  output logic [MW-1:0]      metric
);

`ifndef BM_SOFT_DECISION_EN
  // Hard decision looks only at sample MSBs; fold the rest so they read as intentionally unused.
  logic unused_lsb_s;
  assign unused_lsb_s = ^rx;
`endif

  assign metric = bm_dist(code, rx);

endmodule

// File: rtl/bm_table_unit.sv
// Branch-metric unit: loads the expected codeword table, then emits one metric vector per symbol.
// BM_SOFT_DECISION_EN selects soft L1 metrics; the default build uses Hamming metrics.
module bm_table_unit
  import bm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_ld_valid,
  input  logic [N_OUT-1:0]         i_ld_code,
  output logic                     o_ld_ready,
  output logic                     o_cal_done,
  input  logic                     i_rx_valid,
  input  logic [N_OUT*Q-1:0]       i_rx,
  output logic                     o_rx_ready,
  output logic                     o_bm_valid,
  input  logic                     i_bm_ready,
  output logic [NUM_BRANCH*MW-1:0] o_bm,
  output logic [15:0]              o_sym_cnt
);

  fsm_t                     state_r, state_s;
  logic [IDX_W-1:0]         cnt_r, cnt_s;
  code_t                    table_r [NUM_BRANCH];
  logic [NUM_BRANCH*MW-1:0] metric_s;
  logic                     ld_acc_s, rx_acc_s, consume_s, bm_valid_s;

  // Next-state logic; a start pulse overrides every state and rewinds the load index.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    ld_acc_s = 1'b0;
    if (i_start) begin
      state_s = LOAD;
      cnt_s   = '0;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        LOAD: begin
          if (i_ld_valid) begin
            ld_acc_s = 1'b1;
            cnt_s    = cnt_r + IDX_W'(1);
            if (cnt_r == IDX_W'(NUM_BRANCH - 1)) begin
              state_s = RUN;
            end else begin
              state_s = LOAD;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        RUN:     state_s = RUN;
        default: state_s = IDLE;
      endcase
    end
  end

  assign o_rx_ready = (state_r == RUN) && (!o_bm_valid || i_bm_ready);
  assign rx_acc_s   = o_rx_ready && i_rx_valid && !i_start;
  assign consume_s  = o_bm_valid && i_bm_ready;

  // Output vector occupancy: restart drops it, an accept fills it, a lone consume empties it.
  always_comb begin
    bm_valid_s = o_bm_valid;
    if (i_start) begin
      bm_valid_s = 1'b0;
    end else if (rx_acc_s) begin
      bm_valid_s = 1'b1;
    end else if (consume_s) begin
      bm_valid_s = 1'b0;
    end else begin
      bm_valid_s = o_bm_valid;
    end
  end

  // Control registers; ready/done flags are decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      o_ld_ready <= 1'b0;
      o_cal_done <= 1'b0;
      o_bm_valid <= 1'b0;
      o_sym_cnt  <= 16'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      o_ld_ready <= (state_s == LOAD);
      o_cal_done <= (state_s == RUN);
      o_bm_valid <= bm_valid_s;
      if (consume_s) begin
        o_sym_cnt <= o_sym_cnt + 16'd1;
      end
    end
  end

  // Codeword table, indexed by {input, state}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      table_r <= '{default: '0};
    end else if (ld_acc_s) begin
      table_r[cnt_r] <= i_ld_code;
    end
  end

  for (genvar b = 0; b < NUM_BRANCH; b++) begin : g_branch
    bm_branch_calc u_calc (
      .code   (table_r[b]),
      .rx     (i_rx),
      .metric (metric_s[b*MW +: MW])
    );
  end

  // Metric vector register; held while downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_bm <= '0;
    end else if (rx_acc_s) begin
      o_bm <= metric_s;
    end
  end

endmodule
